// File: rtl/program_rom_fetch_if.sv
// program_rom_fetch_if: CPU-side bus cycle bundle for the program ROM fetch unit.
// The master starts a cycle with a one-cycle req; the slave answers with a one-cycle ready.
interface program_rom_fetch_if;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_hit;

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_hit
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_hit
  );
endinterface

// File: rtl/program_rom_fetch.sv
// program_rom_fetch: decodes CPU bus cycles onto the banked program ROM array.
// One outstanding cycle; ROM reads wait a fixed synchronous latency.
module program_rom_fetch #(
  parameter int unsigned ROM_LATENCY = 1,
  parameter logic [15:0] BANK_ADDR   = 16'h9F24
) (
  input  logic               clk,
  input  logic               reset_n,
  program_rom_fetch_if.slave cpu,
  output logic [12:0]        rom_addr,
  output logic               rom0_n,
  output logic               rom1_n,
  output logic               rom2_n,
  output logic               bank0_n,
  output logic               bank1_n,
  input  logic [7:0]         rom_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] LAT  = 2'(ROM_LATENCY);

  logic [1:0] state;
  logic [1:0] cnt;
  logic [2:0] sel;
  logic       rd_hit;
  logic       b0_wr;
  logic       b1_wr;
  logic       unused_wdata;

  // Only bit 0 of write data feeds the bank latches.
  assign unused_wdata = ^cpu.cpu_wdata[7:1];

  always_comb begin
    sel = 3'b000;
    unique case (1'b1)
      cpu.cpu_addr[15:13] == 3'b101: sel = 3'b001;
      cpu.cpu_addr[15:13] == 3'b110: sel = 3'b010;
      cpu.cpu_addr[15:13] == 3'b111: sel = 3'b100;
      default:                       sel = 3'b000;
    endcase
  end

  assign rd_hit = !cpu.cpu_we && (sel != 3'b000);
  assign b0_wr  = cpu.cpu_we && (cpu.cpu_addr == BANK_ADDR);
  assign b1_wr  = cpu.cpu_we
               && (cpu.cpu_addr == BANK_ADDR + 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      rom_addr      <= 13'd0;
      rom0_n        <= 1'b1;
      rom1_n        <= 1'b1;
      rom2_n        <= 1'b1;
      bank0_n       <= 1'b1;
      bank1_n       <= 1'b1;
      cpu.cpu_ready <= 1'b0;
      cpu.cpu_rdata <= 8'h00;
      cpu.cpu_hit   <= 1'b0;
    end else begin
      cpu.cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            unique case (1'b1)
              rd_hit: begin
                rom_addr    <= cpu.cpu_addr[12:0];
                rom0_n      <= ~sel[0];
                rom1_n      <= ~sel[1];
                rom2_n      <= ~sel[2];
                cnt         <= LAT;
                cpu.cpu_hit <= 1'b1;
                state       <= WAIT;
              end
              b0_wr: begin
                bank0_n       <= ~cpu.cpu_wdata[0];
                cpu.cpu_hit   <= 1'b1;
                cpu.cpu_ready <= 1'b1;
                state         <= DONE;
              end
              b1_wr: begin
                bank1_n       <= ~cpu.cpu_wdata[0];
                cpu.cpu_hit   <= 1'b1;
                cpu.cpu_ready <= 1'b1;
                state         <= DONE;
              end
              default: begin
                // Misses and writes into ROM space complete at once.
                if (!cpu.cpu_we) cpu.cpu_rdata <= 8'hFF;
                cpu.cpu_hit   <= 1'b0;
                cpu.cpu_ready <= 1'b1;
                state         <= DONE;
              end
            endcase
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            cpu.cpu_rdata <= rom_data;
            rom0_n        <= 1'b1;
            rom1_n        <= 1'b1;
            rom2_n        <= 1'b1;
            cpu.cpu_ready <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_one_select: assert property (
    @(posedge clk) disable iff (!reset_n)
    $onehot0({~rom2_n, ~rom1_n, ~rom0_n})
  );

  a_select_in_wait: assert property (
    @(posedge clk) disable iff (!reset_n)
    (state != WAIT) |-> (rom0_n && rom1_n && rom2_n)
  );

endmodule

// File: tb/tb_program_rom_fetch.sv
// tb_program_rom_fetch: two fetch units (latency 1 and 3) on shared CPU stimulus,
// checked each cycle against a transaction-schedule model plus literal spot checks.
module tb_program_rom_fetch;

  localparam logic [15:0] BANK_ADDR = 16'h9F24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;

  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [15:0] addr  = 16'h0000;
  logic [7:0]  wdata = 8'h00;

  program_rom_fetch_if bus0();
  program_rom_fetch_if bus1();

  assign bus0.cpu_req   = req;
  assign bus0.cpu_addr  = addr;
  assign bus0.cpu_we    = we;
  assign bus0.cpu_wdata = wdata;
  assign bus1.cpu_req   = req;
  assign bus1.cpu_addr  = addr;
  assign bus1.cpu_we    = we;
  assign bus1.cpu_wdata = wdata;

  logic        rdy[2];
  logic [7:0]  rdat[2];
  logic        hit[2];
  logic [12:0] ra[2];
  logic        r0n[2];
  logic        r1n[2];
  logic        r2n[2];
  logic        b0[2];
  logic        b1[2];
  logic [7:0]  rd[2];

  assign rdy[0]  = bus0.cpu_ready;
  assign rdat[0] = bus0.cpu_rdata;
  assign hit[0]  = bus0.cpu_hit;
  assign rdy[1]  = bus1.cpu_ready;
  assign rdat[1] = bus1.cpu_rdata;
  assign hit[1]  = bus1.cpu_hit;

  program_rom_fetch #(.ROM_LATENCY(1), .BANK_ADDR(BANK_ADDR)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .cpu(bus0),
    .rom_addr(ra[0]), .rom0_n(r0n[0]), .rom1_n(r1n[0]), .rom2_n(r2n[0]),
    .bank0_n(b0[0]), .bank1_n(b1[0]), .rom_data(rd[0])
  );

  program_rom_fetch #(.ROM_LATENCY(3), .BANK_ADDR(BANK_ADDR)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .cpu(bus1),
    .rom_addr(ra[1]), .rom0_n(r0n[1]), .rom1_n(r1n[1]), .rom2_n(r2n[1]),
    .bank0_n(b0[1]), .bank1_n(b1[1]), .rom_data(rd[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // ROM contents: region 0..2, banked flag (ignored for region 2), 13-bit offset.
  function automatic logic [7:0] mem_fn(input int region, input logic banked,
                                        input logic [12:0] a);
    logic [7:0] v;
    if (region == 2 && a == 13'h0123) return 8'h5A;
    v = 8'(a * 13'd29) ^ {3'b000, a[12:8]};
    v = v ^ 8'(8'(region) * 8'h35);
    if (region != 2 && banked) v = v ^ 8'hA6;
    return v;
  endfunction

  // ROM stub: data is only correct in the cycle exactly LAT cycles into a select.
  int lowcnt[2];
  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) lowcnt[d] <= 0;
      else if (!(r0n[d] && r1n[d] && r2n[d])) lowcnt[d] <= lowcnt[d] + 1;
      else lowcnt[d] <= 0;
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rd[d] = mem_fn(!r0n[d] ? 0 : (!r1n[d] ? 1 : 2), ~b0[d], ra[d])
            ^ ((lowcnt[d] == lat_of(d)) ? 8'h00 : 8'hC3);
    end
  end

  // Model: each accepted cycle schedules its outputs in absolute cycle numbers.
  int          free_at[2];
  int          rdy_at[2];
  int          sel_lo[2];
  int          sel_hi[2];
  int          sel_idx[2];
  int          rdat_at[2];
  logic [7:0]  rdat_old[2];
  logic [7:0]  rdat_new[2];
  logic        hit_e[2];
  logic        b0_e[2];
  logic        b1_e[2];
  logic [12:0] ra_e[2];

  function automatic logic [7:0] eff_rd(input int d);
    return (cyc >= rdat_at[d]) ? rdat_new[d] : rdat_old[d];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        free_at[d]  <= 0;
        rdy_at[d]   <= -1;
        sel_lo[d]   <= 1;
        sel_hi[d]   <= 0;
        sel_idx[d]  <= 0;
        rdat_at[d]  <= 0;
        rdat_old[d] <= 8'h00;
        rdat_new[d] <= 8'h00;
        hit_e[d]    <= 1'b0;
        b0_e[d]     <= 1'b1;
        b1_e[d]     <= 1'b1;
        ra_e[d]     <= 13'd0;
      end else if (req && cyc + 1 >= free_at[d]) begin
        if (addr >= 16'hA000 && !we) begin
          sel_lo[d]   <= cyc + 1;
          sel_hi[d]   <= cyc + 1 + lat_of(d);
          sel_idx[d]  <= int'(addr[15:13]) - 5;
          ra_e[d]     <= addr[12:0];
          hit_e[d]    <= 1'b1;
          rdy_at[d]   <= cyc + 2 + lat_of(d);
          free_at[d]  <= cyc + 4 + lat_of(d);
          rdat_old[d] <= eff_rd(d);
          rdat_new[d] <= mem_fn(int'(addr[15:13]) - 5, ~b0_e[d], addr[12:0]);
          rdat_at[d]  <= cyc + 2 + lat_of(d);
        end else if (we && addr == BANK_ADDR) begin
          b0_e[d]    <= ~wdata[0];
          hit_e[d]   <= 1'b1;
          rdy_at[d]  <= cyc + 1;
          free_at[d] <= cyc + 3;
        end else if (we && addr == BANK_ADDR + 16'd1) begin
          b1_e[d]    <= ~wdata[0];
          hit_e[d]   <= 1'b1;
          rdy_at[d]  <= cyc + 1;
          free_at[d] <= cyc + 3;
        end else begin
          hit_e[d]   <= 1'b0;
          rdy_at[d]  <= cyc + 1;
          free_at[d] <= cyc + 3;
          if (!we) begin
            rdat_old[d] <= eff_rd(d);
            rdat_new[d] <= 8'hFF;
            rdat_at[d]  <= cyc + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int d,
                     input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h",
               nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] es;
        es = 3'b111;
        if (cyc >= sel_lo[d] && cyc <= sel_hi[d]) es[sel_idx[d]] = 1'b0;
        chk("ready", d, 16'(rdy[d]), 16'(cyc == rdy_at[d]));
        chk("selects", d, 16'({r2n[d], r1n[d], r0n[d]}), 16'(es));
        chk("rdata", d, 16'(rdat[d]), 16'(eff_rd(d)));
        chk("hit", d, 16'(hit[d]), 16'(hit_e[d]));
        chk("bank0_n", d, 16'(b0[d]), 16'(b0_e[d]));
        chk("bank1_n", d, 16'(b1[d]), 16'(b1_e[d]));
        if (es != 3'b111) chk("rom_addr", d, 16'(ra[d]), 16'(ra_e[d]));
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a,
                       input logic [7:0] dt);
    req = 1'b1; we = w; addr = a; wdata = dt;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    int n1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", 0, 16'(rdy[0] | rdy[1]), 16'd0);
      chk("idle_sel", 0, 16'({r2n[0], r1n[0], r0n[0], b0[0], b1[0]}), 16'h1F);
    end

    issue(1'b0, 16'hE123, 8'h00);
    chk("e123_sel", 0, 16'(r2n[0]), 16'd0);
    chk("e123_addr", 0, 16'(ra[0]), 16'h0123);
    @(negedge clk);
    chk("e123_sel2", 0, 16'(r2n[0]), 16'd0);
    chk("e123_early", 0, 16'(rdy[0]), 16'd0);
    @(negedge clk);
    chk("e123_ready", 0, 16'(rdy[0]), 16'd1);
    chk("e123_data", 0, 16'(rdat[0]), 16'h005A);
    chk("e123_hit", 0, 16'(hit[0]), 16'd1);
    chk("e123_release", 0, 16'(r2n[0]), 16'd1);
    repeat (4) @(negedge clk);

    issue(1'b1, 16'h9F24, 8'h01);
    chk("bank_set", 0, 16'(b0[0]), 16'd0);
    chk("bank_ready", 0, 16'(rdy[0]), 16'd1);
    @(negedge clk);
    issue(1'b0, 16'hA010, 8'h00);
    chk("a010_sel", 0, 16'({r2n[0], r1n[0], r0n[0]}), 16'h6);
    chk("a010_addr", 0, 16'(ra[0]), 16'h0010);
    repeat (5) @(negedge clk);
    issue(1'b1, 16'h9F24, 8'h00);
    chk("bank_clr", 0, 16'(b0[0]), 16'd1);
    @(negedge clk);

    issue(1'b0, 16'h4000, 8'h00);
    chk("miss_ready", 0, 16'(rdy[0]), 16'd1);
    chk("miss_data", 0, 16'(rdat[0]), 16'h00FF);
    chk("miss_hit", 0, 16'(hit[0]), 16'd0);
    @(negedge clk);
    issue(1'b1, 16'hC000, 8'h01);
    chk("romwr_sel", 0, 16'({r2n[0], r1n[0], r0n[0], b0[0], b1[0]}), 16'h1F);
    chk("romwr_hit", 0, 16'(hit[0]), 16'd0);
    @(negedge clk);

    issue(1'b0, 16'hE200, 8'h00);
    issue(1'b0, 16'hC055, 8'h00);
    chk("second_addr", 1, 16'(ra[1]), 16'h0200);
    n1 = 0;
    repeat (6) begin
      if (rdy[1]) n1++;
      @(negedge clk);
    end
    chk("one_ready", 1, 16'(n1), 16'd1);

    issue(1'b1, 16'h9F24, 8'h01);
    @(negedge clk);
    issue(1'b0, 16'hA100, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sel", 1, 16'({r2n[1], r1n[1], r0n[1], b0[1]}), 16'hF);
    chk("rst_sel", 0, 16'({r2n[0], r1n[0], r0n[0], b0[0]}), 16'hF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n1 = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[0] || rdy[1]) n1++;
    end
    chk("rst_no_ready", 0, 16'(n1), 16'd0);

    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        if (k <= 4)
          issue(1'b0, {3'($urandom_range(5, 7)), 13'($urandom)}, 8'h00);
        else if (k == 5)
          issue(1'b1, BANK_ADDR, 8'($urandom));
        else if (k == 6)
          issue(1'b1, BANK_ADDR + 16'd1, 8'($urandom));
        else if (k == 7)
          issue(1'b1, {3'($urandom_range(5, 7)), 13'($urandom)}, 8'($urandom));
        else if (k == 8)
          issue(1'($urandom), 16'($urandom_range(0, 16'h9FFF)), 8'($urandom));
        else
          issue(1'b0, 16'hFFFC + 16'($urandom_range(0, 3)), 8'h00);
      end else begin
        @(negedge clk);
      end
    end
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
